// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared pipeline constants, reset level and counter-width helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

   localparam int EX2MEM_LANES   = 2;
   localparam int EX2MEM_DW      = 128;
   localparam int EX2MEM_OUT_MAX = 3;
   localparam int MEM2WB_LANES   = 2;
   localparam int MEM2WB_DW      = 128;

   localparam logic RstEnable = 1'b0;

   // Bits needed to hold values 0 .. value-1.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg_nlane_if.sv
// ============================================================================
// Module   : pipe_stage_reg_nlane_if
// Brief    : Handshake, payload and load-tracking bundle of the stage register.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pipe_stage_reg_nlane_if
   import pipe_pkg::*;
#(
   parameter int LANES   = 2,
   parameter int DW      = 128,
   parameter int OUT_MAX = 3
);
   localparam int CW = clog2(OUT_MAX + 1);

   logic                  flush_i;
   logic [LANES-1:0]      pre_valid_i;
   logic [LANES*DW-1:0]   pre_bus_i;
   logic                  pre_allowin_o;
   logic                  nxt_allowin_i;
   logic [LANES-1:0]      now_valid_o;
   logic [LANES*DW-1:0]   now_bus_o;
   logic                  req_issue_i;
   logic                  rdata_ret_i;
   logic                  rdata_discard_o;
   logic [CW-1:0]         out_cnt_o;
   logic [CW-1:0]         cancel_cnt_o;
   logic                  err_o;

   modport slave (
      input  flush_i, pre_valid_i, pre_bus_i, nxt_allowin_i, req_issue_i, rdata_ret_i,
      output pre_allowin_o, now_valid_o, now_bus_o, rdata_discard_o,
             out_cnt_o, cancel_cnt_o, err_o
   );

   modport master (
      output flush_i, pre_valid_i, pre_bus_i, nxt_allowin_i, req_issue_i, rdata_ret_i,
      input  pre_allowin_o, now_valid_o, now_bus_o, rdata_discard_o,
             out_cnt_o, cancel_cnt_o, err_o
   );

endinterface

`default_nettype wire

// File: rtl/ld_cancel_tracker.sv
// ============================================================================
// Module   : ld_cancel_tracker
// Brief    : Counts outstanding data-RAM reads and those orphaned by a flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ld_cancel_tracker
   import pipe_pkg::*;
#(
   parameter int OUT_MAX = 3,
   parameter int CW      = clog2(OUT_MAX + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic          req_issue_i,
   input  logic          rdata_ret_i,
   output logic          rdata_discard_o,
   output logic [CW-1:0] out_cnt_o,
   output logic [CW-1:0] cancel_cnt_o,
   output logic          err_o
);

   localparam logic [CW-1:0] MAX_C = CW'(OUT_MAX);
   localparam logic [CW-1:0] ONE_C = CW'(1);

   logic [CW-1:0] out_q, out_d;
   logic [CW-1:0] cancel_q, cancel_d;
   logic          err_q, err_d;

   always_comb begin
      out_d    = out_q;
      err_d    = err_q;
      cancel_d = cancel_q;
      if (req_issue_i && !rdata_ret_i) begin
         if (out_q == MAX_C) err_d = 1'b1;
         else                out_d = out_q + ONE_C;
      end else if (!req_issue_i && rdata_ret_i) begin
         if (out_q == '0) err_d = 1'b1;
         else             out_d = out_q - ONE_C;
      end else if (req_issue_i && rdata_ret_i && out_q == '0) begin
         err_d = 1'b1;
      end
      // Everything still in flight after this cycle belongs to killed work.
      if (flush_i)                              cancel_d = out_d;
      else if (rdata_ret_i && cancel_q != '0)   cancel_d = cancel_q - ONE_C;
   end

   always_ff @(posedge clk) begin
      if (rst_n == RstEnable) begin
         out_q    <= '0;
         cancel_q <= '0;
         err_q    <= 1'b0;
      end else begin
         out_q    <= out_d;
         cancel_q <= cancel_d;
         err_q    <= err_d;
      end
   end

   assign rdata_discard_o = rdata_ret_i && (cancel_q != '0);
   assign out_cnt_o       = out_q;
   assign cancel_cnt_o    = cancel_q;
   assign err_o           = err_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg_nlane.sv
// ============================================================================
// Module   : pipe_stage_reg_nlane
// Brief    : N-lane inter-stage register with allowin, flush and load tracking.
//            Define PIPE_SKID_BUF_EN for a registered allowin and skid buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_reg_nlane
   import pipe_pkg::*;
#(
   parameter int LANES   = EX2MEM_LANES,
   parameter int DW      = EX2MEM_DW,
   parameter int OUT_MAX = EX2MEM_OUT_MAX
) (
   input  logic                    clk,
   input  logic                    rst_n,
   pipe_stage_reg_nlane_if.slave   bus
);

   logic [LANES-1:0]    valid_q, valid_d;
   logic [LANES*DW-1:0] bus_q, bus_d;
   logic                any_now;
   logic                allowin;

   assign any_now = |valid_q;

`ifdef PIPE_SKID_BUF_EN
   logic [LANES-1:0]    skid_valid_q, skid_valid_d;
   logic [LANES*DW-1:0] skid_bus_q, skid_bus_d;
   logic                skid_full_q, skid_full_d;

   assign allowin = ~skid_full_q;

   always_comb begin
      valid_d      = valid_q;
      bus_d        = bus_q;
      skid_valid_d = skid_valid_q;
      skid_bus_d   = skid_bus_q;
      skid_full_d  = skid_full_q;
      if (bus.flush_i) begin
         valid_d      = '0;
         skid_valid_d = '0;
         skid_full_d  = 1'b0;
      end else if (skid_full_q) begin
         if (bus.nxt_allowin_i) begin
            valid_d = skid_valid_q;
            for (int k = 0; k < LANES; k++)
               if (skid_valid_q[k]) bus_d[k*DW +: DW] = skid_bus_q[k*DW +: DW];
            skid_valid_d = '0;
            skid_full_d  = 1'b0;
         end
      end else if (!any_now || bus.nxt_allowin_i) begin
         valid_d = bus.pre_valid_i;
         for (int k = 0; k < LANES; k++)
            if (bus.pre_valid_i[k]) bus_d[k*DW +: DW] = bus.pre_bus_i[k*DW +: DW];
      end else if (|bus.pre_valid_i) begin
         // Main register is stuck; park the group so allowin can stay registered.
         skid_valid_d = bus.pre_valid_i;
         for (int k = 0; k < LANES; k++)
            if (bus.pre_valid_i[k]) skid_bus_d[k*DW +: DW] = bus.pre_bus_i[k*DW +: DW];
         skid_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n == RstEnable) begin
         skid_valid_q <= '0;
         skid_bus_q   <= '0;
         skid_full_q  <= 1'b0;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_bus_q   <= skid_bus_d;
         skid_full_q  <= skid_full_d;
      end
   end
`else
   assign allowin = bus.nxt_allowin_i || !any_now;

   always_comb begin
      valid_d = valid_q;
      bus_d   = bus_q;
      if (bus.flush_i) begin
         valid_d = '0;
      end else if (allowin) begin
         // An all-zero group simply drains the register.
         valid_d = bus.pre_valid_i;
         for (int k = 0; k < LANES; k++)
            if (bus.pre_valid_i[k]) bus_d[k*DW +: DW] = bus.pre_bus_i[k*DW +: DW];
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst_n == RstEnable) begin
         valid_q <= '0;
         bus_q   <= '0;
      end else begin
         valid_q <= valid_d;
         bus_q   <= bus_d;
      end
   end

   assign bus.pre_allowin_o = allowin;
   assign bus.now_valid_o   = valid_q;
   assign bus.now_bus_o     = bus_q;

   ld_cancel_tracker #(
      .OUT_MAX (OUT_MAX)
   ) u_ld_cancel_tracker (
      .clk             (clk),
      .rst_n           (rst_n),
      .flush_i         (bus.flush_i),
      .req_issue_i     (bus.req_issue_i),
      .rdata_ret_i     (bus.rdata_ret_i),
      .rdata_discard_o (bus.rdata_discard_o),
      .out_cnt_o       (bus.out_cnt_o),
      .cancel_cnt_o    (bus.cancel_cnt_o),
      .err_o           (bus.err_o)
   );

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg_nlane.sv
// ============================================================================
// Module   : tb_pipe_stage_reg_nlane
// Brief    : Directed and random stimulus against a queue-based group model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg_nlane;

   localparam int LANES   = 2;
   localparam int DW      = 128;
   localparam int OUT_MAX = 3;
   localparam int BW      = LANES * DW;

   logic clk;
   logic rst_n;
   bit   chk_en;
   int   n_assert;
   int   n_fail;

   pipe_stage_reg_nlane_if #(.LANES(LANES), .DW(DW), .OUT_MAX(OUT_MAX)) u_if ();

   pipe_stage_reg_nlane #(.LANES(LANES), .DW(DW), .OUT_MAX(OUT_MAX)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: held groups form a FIFO whose head is the visible register.
   typedef struct {
      logic [LANES-1:0] v;
      logic [BW-1:0]    b;
   } grp_t;

   grp_t          q[$];
   grp_t          g_new;
   logic [BW-1:0] m_bus;
   int            m_out;
   int            m_cancel;
   bit            m_err;
   bit            al_v, pop_v, empty_v, iss_v, ret_v;
   int            o_v;

   function automatic bit m_allow();
`ifdef PIPE_SKID_BUF_EN
      return q.size() < 2;
`else
      return u_if.nxt_allowin_i || (q.size() == 0);
`endif
   endfunction

   function automatic logic [LANES-1:0] m_valid();
      return (q.size() > 0) ? q[0].v : '0;
   endfunction

   task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Inputs only change just after posedge, so negedge values are what the next edge samples.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("now_valid",   BW'(u_if.now_valid_o),     BW'(m_valid()));
         chk("now_bus",     u_if.now_bus_o,            m_bus);
         chk("pre_allowin", BW'(u_if.pre_allowin_o),   BW'(m_allow()));
         chk("out_cnt",     BW'(u_if.out_cnt_o),       BW'(m_out));
         chk("cancel_cnt",  BW'(u_if.cancel_cnt_o),    BW'(m_cancel));
         chk("err",         BW'(u_if.err_o),           BW'(m_err));
         chk("discard",     BW'(u_if.rdata_discard_o),
             BW'(u_if.rdata_ret_i && (m_cancel != 0)));
      end
      if (!rst_n) begin
         q.delete();
         m_bus = '0; m_out = 0; m_cancel = 0; m_err = 1'b0;
      end else begin
         al_v  = m_allow();
         iss_v = u_if.req_issue_i;
         ret_v = u_if.rdata_ret_i;
         o_v   = m_out + int'(iss_v) - int'(ret_v);
         if (ret_v && m_out == 0) m_err = 1'b1;
         if (iss_v && !ret_v && m_out == OUT_MAX) m_err = 1'b1;
         if (o_v < 0) o_v = 0;
         if (o_v > OUT_MAX) o_v = OUT_MAX;
         if (u_if.flush_i) m_cancel = o_v;
         else if (ret_v && m_cancel != 0) m_cancel = m_cancel - 1;
         m_out = o_v;
         if (u_if.flush_i) begin
            q.delete();
         end else begin
            empty_v = (q.size() == 0);
            pop_v   = 1'b0;
            if (!empty_v && u_if.nxt_allowin_i) begin
               void'(q.pop_front());
               pop_v = 1'b1;
            end
            if (al_v && |u_if.pre_valid_i) begin
               g_new.v = u_if.pre_valid_i;
               g_new.b = u_if.pre_bus_i;
               q.push_back(g_new);
            end
            if ((pop_v || empty_v) && q.size() > 0)
               for (int k = 0; k < LANES; k++)
                  if (q[0].v[k]) m_bus[k*DW +: DW] = q[0].b[k*DW +: DW];
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic fl, input logic [1:0] pv, input logic [DW-1:0] l1,
                        input logic [DW-1:0] l0, input logic nx, input logic iss, input logic ret);
      u_if.flush_i       = fl;
      u_if.pre_valid_i   = pv;
      u_if.pre_bus_i     = {l1, l0};
      u_if.nxt_allowin_i = nx;
      u_if.req_issue_i   = iss;
      u_if.rdata_ret_i   = ret;
   endtask

   task automatic rnd_cycle();
      logic [BW-1:0] rb;
      for (int w = 0; w < BW / 32; w++) rb[w*32 +: 32] = $urandom;
      u_if.flush_i       = ($urandom_range(0, 15) == 0);
      u_if.pre_valid_i   = LANES'($urandom);
      u_if.pre_bus_i     = rb;
      u_if.nxt_allowin_i = $urandom_range(0, 1) == 1;
      u_if.req_issue_i   = ($urandom_range(0, 2) == 0);
      u_if.rdata_ret_i   = ($urandom_range(0, 2) == 0);
      cyc();
   endtask

   logic [DW-1:0] exp_l0;

   initial begin
      n_assert = 0;
      n_fail   = 0;
      chk_en   = 1'b0;
      rst_n    = 1'b0;
      drive(0, 2'b00, '0, '0, 0, 0, 0);
`ifdef PIPE_SKID_BUF_EN
      exp_l0 = DW'(16'h10);
`else
      exp_l0 = DW'(16'hC);
`endif
      repeat (2) cyc();

      rst_n  = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst now_valid", BW'(u_if.now_valid_o), '0);
      chk("rst now_bus", u_if.now_bus_o, '0);
      chk("rst out_cnt", BW'(u_if.out_cnt_o), '0);
      chk("rst cancel_cnt", BW'(u_if.cancel_cnt_o), '0);
      chk("rst err", BW'(u_if.err_o), '0);
      chk("rst pre_allowin", BW'(u_if.pre_allowin_o), BW'(1));
      cyc();

      drive(0, 2'b11, DW'(16'hB), DW'(16'hA), 1, 0, 0); cyc();
      drive(0, 2'b01, DW'(16'hD), DW'(16'hC), 1, 0, 0);
      @(negedge clk);
      chk("first valid", BW'(u_if.now_valid_o), BW'(2'b11));
      chk("first bus", u_if.now_bus_o, {DW'(16'hB), DW'(16'hA)});
      chk("first allowin", BW'(u_if.pre_allowin_o), BW'(1));
      cyc();

      drive(0, 2'b11, DW'(16'h11), DW'(16'h10), 0, 0, 0);
      @(negedge clk);
      chk("lane keep bus", u_if.now_bus_o, {DW'(16'hB), DW'(16'hC)});
`ifdef PIPE_SKID_BUF_EN
      chk("stall allowin", BW'(u_if.pre_allowin_o), BW'(1));
`else
      chk("stall allowin", BW'(u_if.pre_allowin_o), BW'(0));
`endif
      cyc();

      drive(0, 2'b00, '0, '0, 0, 0, 0);
      @(negedge clk);
      chk("held valid", BW'(u_if.now_valid_o), BW'(2'b01));
      chk("held allowin", BW'(u_if.pre_allowin_o), BW'(0));
      cyc();

      drive(0, 2'b00, '0, '0, 1, 0, 0); cyc();
      drive(0, 2'b10, DW'(16'h22), DW'(16'hF), 1, 0, 0);
      @(negedge clk);
`ifdef PIPE_SKID_BUF_EN
      chk("skid emerge", u_if.now_bus_o, {DW'(16'h11), DW'(16'h10)});
`else
      chk("drained valid", BW'(u_if.now_valid_o), BW'(0));
`endif
      cyc();

      drive(0, 2'b00, '0, '0, 0, 0, 0);
      @(negedge clk);
      chk("partial valid", BW'(u_if.now_valid_o), BW'(2'b10));
      chk("partial bus", u_if.now_bus_o, {DW'(16'h22), exp_l0});
      cyc();

      drive(1, 2'b11, DW'(16'h44), DW'(16'h33), 1, 0, 0); cyc();
      drive(0, 2'b00, '0, '0, 0, 1, 0);
      @(negedge clk);
      chk("flush valid", BW'(u_if.now_valid_o), BW'(0));
      chk("flush bus", u_if.now_bus_o, {DW'(16'h22), exp_l0});
      cyc();

      drive(0, 2'b00, '0, '0, 0, 1, 0); cyc();
      drive(1, 2'b00, '0, '0, 0, 1, 0); cyc();
      drive(0, 2'b00, '0, '0, 0, 0, 1);
      @(negedge clk);
      chk("cancel after flush", BW'(u_if.cancel_cnt_o), BW'(3));
      chk("out after flush", BW'(u_if.out_cnt_o), BW'(3));
      chk("discard 1", BW'(u_if.rdata_discard_o), BW'(1));
      cyc();
      @(negedge clk);
      chk("discard 2", BW'(u_if.rdata_discard_o), BW'(1));
      cyc();
      @(negedge clk);
      chk("discard 3", BW'(u_if.rdata_discard_o), BW'(1));
      cyc();
      drive(0, 2'b00, '0, '0, 0, 1, 0); cyc();
      drive(0, 2'b00, '0, '0, 0, 0, 1);
      @(negedge clk);
      chk("discard 4", BW'(u_if.rdata_discard_o), BW'(0));
      chk("out post flush", BW'(u_if.out_cnt_o), BW'(1));
      cyc();

      drive(0, 2'b00, '0, '0, 0, 0, 1); cyc();
      drive(0, 2'b00, '0, '0, 0, 0, 0);
      @(negedge clk);
      chk("underflow err", BW'(u_if.err_o), BW'(1));
      chk("underflow out", BW'(u_if.out_cnt_o), BW'(0));
      repeat (3) cyc();
      @(negedge clk);
      chk("err sticky", BW'(u_if.err_o), BW'(1));
      cyc();

      rst_n = 1'b0; cyc();
      rst_n = 1'b1;
      @(negedge clk);
      chk("err cleared", BW'(u_if.err_o), BW'(0));
      cyc();

      for (int i = 0; i < 1500; i++) rnd_cycle();
      rst_n = 1'b0; cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 1500; i++) rnd_cycle();

      drive(0, 2'b00, '0, '0, 1, 0, 0);
      repeat (2) cyc();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg_nlane.md
Name: pipe_stage_reg_nlane

Overview:
- Parametrised N-lane inter-stage pipeline register for the multi-issue core, e.g. EX->MEM and MEM->WB.
- Provides per-lane valid latching, allowin back-pressure, and exception flush.
- Tracks outstanding data-RAM read requests, so read data returning for flushed instructions is flagged for discard rather than written back.
- Sits between one stage's combinational logic and the next stage's combinational logic.

Parameters:
- LANES, 2, number of issue lanes.
- DW, 128, payload width per lane in bits.
- OUT_MAX, 3, maximum outstanding data-RAM read requests tracked.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- flush_i  in  1  exception/branch flush; kills all held lanes.
- pre_valid_i  in  LANES  per-lane valid from the previous stage.
- pre_bus_i  in  LANES*DW  per-lane payload; lane k occupies bits [k*DW +: DW].
- pre_allowin_o  out  1  this register can accept a new group this cycle.
- nxt_allowin_i  in  1  the next stage accepts the currently held group.
- now_valid_o  out  LANES  per-lane valid of the held group.
- now_bus_o  out  LANES*DW  held payload.
- req_issue_i  in  1  a data-RAM read request was accepted this cycle.
- rdata_ret_i  in  1  read data returns this cycle.
- rdata_discard_o  out  1  the returning data belongs to a flushed request; drop it.
- out_cnt_o  out  $clog2(OUT_MAX+1)  outstanding requests.
- cancel_cnt_o  out  $clog2(OUT_MAX+1)  outstanding requests already cancelled.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst_n=0 at posedge): now_valid_o=0, now_bus_o=0, out_cnt=0, cancel_cnt=0, err_o=0; skid buffer empty.
- any_now = |now_valid_o.
- Default mode: pre_allowin_o = nxt_allowin_i || !any_now (combinational).
- Accept condition: pre_allowin_o && |pre_valid_i.
  - On accept, now_valid_o <= pre_valid_i.
  - Lane k payload loads only when pre_valid_i[k]=1; invalid lanes keep their old payload.
- Drain with no new group (pre_allowin_o && !|pre_valid_i): now_valid_o <= 0; payload holds.
- Otherwise all state holds.
- Latency is 1 cycle, pre to now.
- flush_i has priority over any accept: now_valid_o <= 0, skid buffer cleared, payload unchanged.
- Outstanding counter: out_cnt += req_issue_i - rdata_ret_i each cycle.
  - Return with out_cnt=0: err_o set, counter stays at 0.
  - Issue with out_cnt=OUT_MAX and no return: err_o set, counter saturates.
- Cancel counter:
  - On flush_i: cancel_cnt <= out_cnt + req_issue_i - rdata_ret_i. A request issued in the flush cycle counts as cancelled; a return in the flush cycle is judged against the old cancel_cnt.
  - Otherwise, on rdata_ret_i with cancel_cnt!=0: cancel_cnt decrements.
- rdata_discard_o = rdata_ret_i && cancel_cnt!=0 (combinational, pre-update value).
- Invariant: cancel_cnt <= out_cnt at all times.
- err_o clears only on reset.

Optional Feature:
- Macro PIPE_SKID_BUF_EN.
- When defined:
  - A one-group skid buffer (LANES valids + payload) is added.
  - pre_allowin_o = !skid_full, driven from a flop, which breaks the combinational allowin chain.
  - A group accepted while the main register is full and nxt_allowin_i=0 goes into the skid buffer.
  - When nxt_allowin_i=1 and the skid buffer is full, the main register reloads from the skid buffer next cycle; order is preserved.
  - Max occupancy is 2 groups.
- When undefined: the default mode above, with zero extra state.

Decomposition:
- Shared package pipe_pkg:
  - lane-count and payload-width constants per stage, e.g. EX2MEM_DW.
  - counter-width function clog2.
  - RstEnable=1'b0.
- One natural sub-module: ld_cancel_tracker, holding out_cnt, cancel_cnt, rdata_discard_o and err_o.
- The lane register and skid logic stay in the top module.

Test Plan:
- Reset, then pre_valid=2'b11 with bus lane0=0xA, lane1=0xB, nxt_allowin=1 -> next cycle now_valid=2'b11, bus=A/B; pre_allowin stays 1.
- Held group 2'b01 with nxt_allowin=0, new pre_valid=2'b11 -> pre_allowin=0, group held unchanged.
  - With skid: the new group goes to skid, pre_allowin=0 next cycle; after nxt_allowin=1, the groups emerge in order.
- pre_valid=2'b10 with lane0 bus=0xF -> lane0 payload keeps its previous value; now_valid=2'b10.
- 2 requests issued, flush_i pulsed together with a 3rd request -> cancel_cnt=3.
  - The next 3 rdata_ret pulses each give rdata_discard=1; the 4th return, for a post-flush request, gives discard=0.
- flush_i and an accept in the same cycle -> now_valid=0; the accepted group is dropped.
- rdata_ret_i with out_cnt=0 -> err_o=1 and stays 1 until reset; out_cnt remains 0.
